// File: rtl/ram8_clr.sv
// Eight-word x 16-bit register-file memory with combinational read, clocked write
// and a hardware clear sweep. Optional write bypass: define RAM8_WRITE_BYPASS_EN.

module dmux8way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic [7:0] out
);
  always_comb begin
    out      = '0;
    out[sel] = in;
  end
endmodule

module ram8_clr (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [2:0]  address,
  input  logic        clear,
  output logic [15:0] out,
  output logic        busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t      state, next_state;
  logic [2:0]  ptr, next_ptr;
  logic        user_load;
  logic        sweep_we;
  logic [7:0]  load_vec;
  logic [7:0]  clr_vec;
  logic [15:0] words [8];

  // NOTE: every output of a combinational block gets a default before any branch,
  // otherwise a path that skips an assignment infers a latch.
  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    user_load  = 1'b0;
    sweep_we   = 1'b0;
    unique case (state)
      IDLE: begin
        if (clear) begin
          next_state = CLEAR;
          next_ptr   = 3'd0;
        end else begin
          user_load = load;
        end
      end
      CLEAR: begin
        sweep_we = 1'b1;
        if (ptr == 3'd7) begin
          next_state = IDLE;
          next_ptr   = 3'd0;
        end else begin
          next_ptr = ptr + 3'd1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // User writes and sweep clears are decoded separately; they never overlap in time.
  dmux8way u_load_dmux (
    .in  (user_load),
    .sel (address),
    .out (load_vec)
  );

  dmux8way u_clr_dmux (
    .in  (sweep_we),
    .sel (ptr),
    .out (clr_vec)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 3'd0;
      // NOTE: the words are plain registers, not a RAM macro, so resetting them is
      // cheap and gives the architecturally required all-zero state.
      for (int i = 0; i < 8; i++) words[i] <= '0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
      for (int i = 0; i < 8; i++) begin
        if (clr_vec[i])       words[i] <= '0;
        else if (load_vec[i]) words[i] <= in;
      end
    end
  end

  assign busy = (state == CLEAR);

`ifdef RAM8_WRITE_BYPASS_EN
  // A write that will be accepted this edge is forwarded straight to the read port.
  always_comb begin
    if (!reset && user_load) out = in;
    else                     out = words[address];
  end
`else
  assign out = words[address];
`endif

endmodule

// File: tb/tb_ram8_clr.sv
// Scoreboard bench for ram8_clr: stimulus pushes expected (out, busy) per cycle,
// a negedge monitor pops and compares against the live DUT outputs.

module tb_ram8_clr;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic        load;
  logic [2:0]  address;
  logic        clear;
  logic [15:0] dout;
  logic        busy;

  ram8_clr dut (
    .clk     (clk),
    .reset   (reset),
    .in      (din),
    .load    (load),
    .address (address),
    .clear   (clear),
    .out     (dout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [15:0] out;
    bit          busy;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;

  // Reference model: memory array plus count of sweep cycles still to run.
  logic [15:0] mem [8];
  int          sweep_left = 0;

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk) begin
        tests++;
        if (dout !== e.out || busy !== e.busy) begin
          fails++;
          $display("FAIL %s: out=%h busy=%0b, expected out=%h busy=%0b",
                   e.tag, dout, busy, e.out, e.busy);
        end
      end
    end
  end

  function automatic logic [15:0] model_out(input logic r, input logic c,
                                            input logic l, input logic [2:0] a,
                                            input logic [15:0] d);
`ifdef RAM8_WRITE_BYPASS_EN
    if (!r && sweep_left == 0 && l && !c) return d;
`endif
    return mem[a];
  endfunction

  task automatic model_edge(input logic r, input logic c, input logic l,
                            input logic [2:0] a, input logic [15:0] d);
    if (r) begin
      foreach (mem[i]) mem[i] = 16'h0000;
      sweep_left = 0;
    end else if (sweep_left > 0) begin
      mem[8 - sweep_left] = 16'h0000;
      sweep_left--;
    end else if (c) begin
      sweep_left = 8;
    end else if (l) begin
      mem[a] = d;
    end
  endtask

  // Drive one cycle: apply inputs, record expectation, clock, advance model.
  task automatic cycle(input logic r, input logic c, input logic l,
                       input logic [2:0] a, input logic [15:0] d,
                       input string tag, input bit chk = 1'b1);
    exp_t e;
    reset = r; clear = c; load = l; address = a; din = d;
    #1;
    e.chk  = chk;
    e.out  = model_out(r, c, l, a, d);
    e.busy = (sweep_left > 0);
    e.tag  = tag;
    exp_q.push_back(e);
    @(posedge clk);
    model_edge(r, c, l, a, d);
    #1;
  endtask

  task automatic read_all(input string tag);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b0, 3'(k), 16'h0, tag);
  endtask

  task automatic fill(input logic [15:0] base);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b1, 3'(k), base + 16'(k), "fill");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; load = 1'b0; address = 3'd0; din = 16'h0;
    foreach (mem[i]) mem[i] = 16'hxxxx;
    @(posedge clk); #1;

    // Reset state: first sample precedes the reset edge so words are still unknown.
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, "reset_pre", 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 3'd4, 16'h5555, "reset_prio");
    read_all("reset_read");

    // Distinct pattern per word, read back.
    fill(16'h1000);
    read_all("readback");

    // Write 0xBEEF to address 5: pre-edge sample depends on bypass, then read.
    cycle(1'b0, 1'b0, 1'b1, 3'd5, 16'hBEEF, "beef_pre");
    cycle(1'b0, 1'b0, 1'b0, 3'd5, 16'h0, "beef_post");

    // Full sweep with load held on address 3, clear re-requested mid-sweep.
    fill(16'h2000);
    cycle(1'b0, 1'b1, 1'b1, 3'd3, 16'hFFFF, "sweep_start");
    for (int k = 0; k < 8; k++)
      cycle(1'b0, (k == 4), 1'b1, 3'd3, 16'hFFFF, "sweep_hold");
    read_all("after_sweep");

    // Sweep with rolling read address to observe progressive zeroing.
    fill(16'h3000);
    cycle(1'b0, 1'b1, 1'b0, 3'd0, 16'h0, "sweep2_start");
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b0, 3'(k), 16'h0, "sweep2_walk");
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b0, 3'(7 - k), 16'h0, "sweep2_done");

    // Reset aborts a sweep at N+4; a write at N+5 succeeds.
    fill(16'h4000);
    cycle(1'b0, 1'b1, 1'b0, 3'd6, 16'h0, "abort_start");
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 3'd6, 16'h0, "abort_mid");
    cycle(1'b1, 1'b0, 1'b0, 3'd6, 16'h0, "abort_reset");
    cycle(1'b0, 1'b0, 1'b1, 3'd2, 16'h1234, "abort_write");
    read_all("abort_read");

    // clear and load on the same IDLE edge: write dropped.
    fill(16'h5000);
    cycle(1'b0, 1'b1, 1'b1, 3'd0, 16'hAAAA, "clr_load");
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, "clr_load_sweep");
    cycle(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, "clr_load_w0");
    cycle(1'b0, 1'b0, 1'b1, 3'd0, 16'h6666, "first_load");
    cycle(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, "first_load_rd");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic r, c, l;
      r = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 99) < 8);
      l = ($urandom_range(0, 99) < 55);
      cycle(r, c, l, 3'($urandom_range(0, 7)), 16'($urandom), "random");
    end
    read_all("final_read");

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
